// File: rtl/param_regfile.sv
// Parameterised register file with combinational write-through reads and a
// per-register pending scoreboard for in-flight destination registers.
module param_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regWrite,
  input  logic [AW-1:0]   writeAddr,
  input  logic [XLEN-1:0] writeData,
  input  logic [AW-1:0]   readAddr1,
  input  logic [AW-1:0]   readAddr2,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  input  logic            issueValid,
  input  logic [AW-1:0]   issueRd,
  output logic            issueReady,
  output logic            rs1Busy,
  output logic            rs2Busy
);

  // Register 0 is hard-wired to zero, so storage only covers 1..NREGS-1.
  logic [XLEN-1:0]  regs_q [1:NREGS-1];
  logic [NREGS-1:1] pending_q;
  logic [NREGS-1:1] pending_d;

  logic wrEn;
  logic issueFire;
  logic pendIssue;
  logic pendRead1;
  logic pendRead2;
  logic wrHitIssue;
  logic wrHitRead1;
  logic wrHitRead2;

  always_comb begin
    wrEn       = 1'b0;
    issueFire  = 1'b0;
    pendIssue  = 1'b0;
    pendRead1  = 1'b0;
    pendRead2  = 1'b0;
    wrHitIssue = 1'b0;
    wrHitRead1 = 1'b0;
    wrHitRead2 = 1'b0;
    issueReady = 1'b1;
    rs1Busy    = 1'b0;
    rs2Busy    = 1'b0;
    rs1        = '0;
    rs2        = '0;
    pending_d  = pending_q;

    if (rst) begin
      wrEn       = regWrite && (writeAddr != '0);
      wrHitIssue = regWrite && (writeAddr == issueRd);
      wrHitRead1 = regWrite && (writeAddr == readAddr1);
      wrHitRead2 = regWrite && (writeAddr == readAddr2);

      if (issueRd != '0)   pendIssue = pending_q[issueRd];
      if (readAddr1 != '0) pendRead1 = pending_q[readAddr1];
      if (readAddr2 != '0) pendRead2 = pending_q[readAddr2];

      issueReady = (issueRd == '0) || !pendIssue || wrHitIssue;
      issueFire  = issueValid && issueReady && (issueRd != '0);

      rs1Busy = pendRead1 && !wrHitRead1;
      rs2Busy = pendRead2 && !wrHitRead2;

      if (readAddr1 != '0) rs1 = (wrEn && wrHitRead1) ? writeData : regs_q[readAddr1];
      if (readAddr2 != '0) rs2 = (wrEn && wrHitRead2) ? writeData : regs_q[readAddr2];

      // Set is applied after clear so a same-cycle re-issue keeps the bit.
      if (wrEn)      pending_d[writeAddr] = 1'b0;
      if (issueFire) pending_d[issueRd]   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
      pending_q <= '0;
    end else begin
      if (wrEn) regs_q[writeAddr] <= writeData;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_param_regfile.sv
// Scoreboard bench for param_regfile: directed vectors push expected outputs,
// a monitor on the falling edge pops and compares them.
module tb_param_regfile;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            regWrite = 1'b0;
  logic [AW-1:0]   writeAddr = '0;
  logic [XLEN-1:0] writeData = '0;
  logic [AW-1:0]   readAddr1 = '0;
  logic [AW-1:0]   readAddr2 = '0;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            issueValid = 1'b0;
  logic [AW-1:0]   issueRd = '0;
  logic            issueReady;
  logic            rs1Busy;
  logic            rs2Busy;

  typedef struct {
    string           name;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            b1;
    logic            b2;
    logic            rdy;
  } exp_t;

  exp_t expQ[$];
  logic stimValid = 1'b0;
  int   testCount = 0;
  int   failCount = 0;

  param_regfile #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .regWrite  (regWrite),
    .writeAddr (writeAddr),
    .writeData (writeData),
    .readAddr1 (readAddr1),
    .readAddr2 (readAddr2),
    .rs1       (rs1),
    .rs2       (rs2),
    .issueValid(issueValid),
    .issueRd   (issueRd),
    .issueReady(issueReady),
    .rs1Busy   (rs1Busy),
    .rs2Busy   (rs2Busy)
  );

  always #5 clk = ~clk;

  task automatic compareField(input string name, input string field,
                              input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField(e.name, "rs1",        rs1,        e.rs1);
    compareField(e.name, "rs2",        rs2,        e.rs2);
    compareField(e.name, "rs1Busy",    {31'b0, rs1Busy},    {31'b0, e.b1});
    compareField(e.name, "rs2Busy",    {31'b0, rs2Busy},    {31'b0, e.b2});
    compareField(e.name, "issueReady", {31'b0, issueReady}, {31'b0, e.rdy});
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle after stimulus settles.
  initial begin
    forever begin
      @(negedge clk);
      if (stimValid) begin
        if (expQ.size() == 0) begin
          testCount++;
          failCount++;
          $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
          checkOutput(expQ.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(
    input string name, input logic rstV,
    input logic rw, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
    input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
    input logic iv, input logic [AW-1:0] ird,
    input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
    input logic eb1, input logic eb2, input logic erdy);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = rstV;
    regWrite   = rw;
    writeAddr  = wa;
    writeData  = wd;
    readAddr1  = ra1;
    readAddr2  = ra2;
    issueValid = iv;
    issueRd    = ird;
    e.name = name; e.rs1 = e1; e.rs2 = e2; e.b1 = eb1; e.b2 = eb2; e.rdy = erdy;
    expQ.push_back(e);
    stimValid = 1'b1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    //            name            rst rw wa  wd            ra1 ra2 iv ird  rs1           rs2           b1 b2 rdy
    applyStimulus("in_reset",     0, 1, 1,  32'hffffffff, 1,  0,  1, 3,   32'h0,        32'h0,        0, 0, 1);
    applyStimulus("wr_x1",        1, 1, 1,  32'hbeeeeeef, 1,  2,  0, 0,   32'hbeeeeeef, 32'h0,        0, 0, 1);
    applyStimulus("rd_x1",        1, 0, 0,  32'h0,        1,  1,  0, 0,   32'hbeeeeeef, 32'hbeeeeeef, 0, 0, 1);
    applyStimulus("bypass_x5",    1, 1, 5,  32'h1234,     1,  5,  0, 0,   32'hbeeeeeef, 32'h1234,     0, 0, 1);
    applyStimulus("wr_x0",        1, 1, 0,  32'hffffffff, 0,  5,  1, 0,   32'h0,        32'h1234,     0, 0, 1);
    applyStimulus("issue_x7",     1, 0, 0,  32'h0,        7,  0,  1, 7,   32'h0,        32'h0,        0, 0, 1);
    applyStimulus("reissue_x7",   1, 0, 0,  32'h0,        7,  5,  1, 7,   32'h0,        32'h1234,     1, 0, 0);
    applyStimulus("wb_x7",        1, 1, 7,  32'ha5,       7,  7,  0, 7,   32'ha5,       32'ha5,       0, 0, 1);
    applyStimulus("issue_x3",     1, 0, 0,  32'h0,        7,  0,  1, 3,   32'ha5,       32'h0,        0, 0, 1);
    applyStimulus("setclr_x3",    1, 1, 3,  32'h33,       3,  7,  1, 3,   32'h33,       32'ha5,       0, 0, 1);
    applyStimulus("x3_busy",      1, 0, 0,  32'h0,        3,  3,  0, 3,   32'h33,       32'h33,       1, 1, 0);
    applyStimulus("wr_x9",        1, 1, 9,  32'h55,       9,  3,  0, 3,   32'h55,       32'h33,       0, 1, 0);
    applyStimulus("issue_x9",     1, 0, 0,  32'h0,        9,  0,  1, 9,   32'h55,       32'h0,        0, 0, 1);
    applyStimulus("x9_busy",      1, 0, 0,  32'h0,        9,  3,  0, 9,   32'h55,       32'h33,       1, 1, 0);
    applyStimulus("mid_reset",    0, 1, 9,  32'hff,       9,  3,  1, 9,   32'h0,        32'h0,        0, 0, 1);
    applyStimulus("post_reset",   1, 0, 0,  32'h0,        9,  1,  1, 9,   32'h0,        32'h0,        0, 0, 1);
    applyStimulus("x9_repending", 1, 0, 0,  32'h0,        9,  7,  0, 9,   32'h0,        32'h0,        1, 0, 0);
    stimValid = 1'b0;

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
    testCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d entries left, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 Parameter XLEN, default 32, data width of each register in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers (power of two, at least 2).
REQ-003 Parameter AW, default $clog2(NREGS), register address width; SHALL NOT be overridden independently of NREGS.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 regWrite  input  1  writeback enable.
REQ-007 writeAddr  input  AW  writeback destination register.
REQ-008 writeData  input  XLEN  writeback data.
REQ-009 readAddr1  input  AW  read port 1 address.
REQ-010 readAddr2  input  AW  read port 2 address.
REQ-011 rs1  output  XLEN  read port 1 data (combinational).
REQ-012 rs2  output  XLEN  read port 2 data (combinational).
REQ-013 issueValid  input  1  request to mark a destination register pending.
REQ-014 issueRd  input  AW  destination register being issued.
REQ-015 issueReady  output  1  issue accepted this cycle.
REQ-016 rs1Busy  output  1  read port 1 operand not yet available.
REQ-017 rs2Busy  output  1  read port 2 operand not yet available.

Function
REQ-018 Storage SHALL be NREGS registers of XLEN bits plus NREGS pending bits; register 0 SHALL read as zero and hold no state.
REQ-019 Write: when regWrite=1 and writeAddr!=0, register[writeAddr] SHALL take writeData at the clock edge; writes to address 0 SHALL be ignored.
REQ-020 Read bypass: when regWrite=1, writeAddr!=0 and readAddrN==writeAddr, rsN SHALL equal writeData in the same cycle (zero-latency write-through).
REQ-021 Read of address 0 SHALL return 0 regardless of regWrite/writeData.
REQ-022 Otherwise rsN SHALL equal the stored register[readAddrN].
REQ-023 Pending clear: an accepted write to address A (A!=0) SHALL clear pending[A] at the edge.
REQ-024 issueReady SHALL be 1 iff issueRd==0, or pending[issueRd]=0, or (regWrite=1 and writeAddr==issueRd).
REQ-025 Pending set: when issueValid=1, issueReady=1 and issueRd!=0, pending[issueRd] SHALL be set at the edge.
REQ-026 Simultaneous set and clear of the same register in one cycle: set SHALL win (pending stays 1).
REQ-027 Issue to address 0 SHALL be accepted (issueReady=1) and SHALL NOT change any pending bit.
REQ-028 issueValid=1 with issueReady=0 SHALL leave all state unchanged; the requester holds and retries.
REQ-029 rsNBusy SHALL be 1 iff readAddrN!=0, pending[readAddrN]=1, and not (regWrite=1 and writeAddr==readAddrN).
REQ-030 pending[0] SHALL read as 0 at all times.
REQ-031 regWrite to a register whose pending bit is 0 SHALL still update data (no scoreboard check on writeback).

Reset
REQ-032 rst=0 SHALL asynchronously clear all registers to 0 and all pending bits to 0, independent of clk.
REQ-033 During reset rs1=rs2=0, rs1Busy=rs2Busy=0, issueReady=1; writes and issues SHALL be ignored.
REQ-034 Deassertion mid-sequence SHALL resume with all-zero state on the first rising edge with rst=1.

Verification
REQ-035 Reset then write 32'hbeeeeeef to x1, next cycle readAddr1=1 -> rs1=32'hbeeeeeef, rs1Busy=0.
REQ-036 regWrite=1, writeAddr=5, writeData=32'h1234, readAddr2=5 same cycle -> rs2=32'h1234 before the edge.
REQ-037 Write 32'hffffffff to x0, readAddr1=0 -> rs1=0; issueRd=0 -> issueReady=1, no pending change.
REQ-038 Issue x7, then readAddr1=7 -> rs1Busy=1; second issue x7 -> issueReady=0; writeback x7=32'hA5 -> rs1Busy=0 same cycle, rs1=32'hA5.
REQ-039 Pending x3; same cycle regWrite x3 and issueValid x3 -> issueReady=1, next cycle pending[3]=1 (rs busy on x3).
REQ-040 Write x9=32'h55, issue x9, assert rst=0 mid-cycle -> immediately rs1(x9)=0, rs1Busy=0; after release issue x9 accepted.
